// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and widths for the unified-memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_D    = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/acknowledge memory port: the arbiter is the master, the memory the slave.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises instruction fetch and data accesses onto one single-ported memory.
// Data has priority; a streak counter forces a fetch after STARVE_MAX data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_kill,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [BE_W-1:0]   d_be,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  mem_port_arbiter_if.master mem,
  output logic              busy
);

  localparam logic [2:0] STREAK_CAP = 3'(STARVE_MAX);

  arb_state_t state;
  owner_t     done_own;
  logic [2:0] streak;
  logic       discard;
  logic       if_cand;
  logic       d_cand;
  logic       force_if;

  function automatic logic [2:0] streak_inc(input logic [2:0] s);
    return (s >= STREAK_CAP) ? STREAK_CAP : s + 3'd1;
  endfunction

  // The port that completed last cycle sits out the grant decision of its ready cycle.
  always_comb begin
    if_cand  = if_req && !if_kill && (done_own != OWN_IF);
    d_cand   = d_req && (done_own != OWN_D);
    force_if = if_cand && (streak == STREAK_CAP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      done_own      <= OWN_NONE;
      streak        <= '0;
      discard       <= 1'b0;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      mem.mem_be    <= '0;
      if_ready      <= 1'b0;
      d_ready       <= 1'b0;
      if_rdata      <= '0;
      d_rdata       <= '0;
      busy          <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      done_own <= OWN_NONE;
      if (!if_req) streak <= '0;

      unique case (state)
        IDLE: begin
          if (force_if || (if_cand && !d_cand)) begin
            state        <= FETCH;
            busy         <= 1'b1;
            mem.mem_req  <= 1'b1;
            mem.mem_we   <= 1'b0;
            mem.mem_addr <= if_addr;
            mem.mem_be   <= '1;
            streak       <= '0;
          end else if (d_cand) begin
            state         <= DATA;
            busy          <= 1'b1;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= d_we;
            mem.mem_addr  <= d_addr;
            mem.mem_wdata <= d_wdata;
            mem.mem_be    <= d_be;
            if (if_req) streak <= streak_inc(streak);
          end
        end

        // A kill arriving with the ack still discards the returning instruction.
        FETCH: begin
          if (mem.mem_ack) begin
            state       <= IDLE;
            busy        <= 1'b0;
            mem.mem_req <= 1'b0;
            done_own    <= OWN_IF;
            discard     <= 1'b0;
            if (!discard && !if_kill) begin
              if_rdata <= mem.mem_rdata;
              if_ready <= 1'b1;
            end
          end else if (if_kill) begin
            discard <= 1'b1;
          end
        end

        DATA: begin
          if (mem.mem_ack) begin
            state       <= IDLE;
            busy        <= 1'b0;
            mem.mem_req <= 1'b0;
            done_own    <= OWN_D;
            d_ready     <= 1'b1;
            if (!mem.mem_we) d_rdata <= mem.mem_rdata;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
